// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one request at a time, holds each fetched word
// for decode, and handles redirects. Define FETCH_ALIGN_CHECK_EN to trap misaligned redirects.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] iaddr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] idata,
    output logic [31:0] pc,
    output logic        instr_valid,
    input  logic        dec_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err
);

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_VALID = 3'd2,
        S_DROP  = 3'd3,
        S_ERR   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_VALID = 3'd2,
        S_DROP  = 3'd3
    } state_t;
`endif

    state_t      r_state;
    logic [31:0] r_iaddr;
    logic [31:0] r_pc;
    logic [31:0] r_idata;
    logic [31:0] r_pend_pc;
    logic        r_req;
    logic        r_valid;

    logic [31:0] w_tgt;
    logic [31:0] w_l_pc;
    logic [31:0] w_pc_inc;
    logic        w_do_launch;

`ifdef FETCH_ALIGN_CHECK_EN
    logic        r_err;
    logic        r_pend_bad;
    logic        w_bad;
    logic        w_l_bad;

    assign w_tgt   = redirect_pc;
    assign w_bad   = |redirect_pc[1:0];
    assign w_l_bad = (r_state == S_DROP && !redirect_valid) ? r_pend_bad : w_bad;
    assign fetch_err = r_err;
`else
    assign w_tgt     = redirect_pc & 32'hFFFF_FFFC;
    assign fetch_err = 1'b0;
`endif

    // A pending target from DROP is used only if no newer redirect arrives with the ack.
    assign w_l_pc   = (r_state == S_DROP && !redirect_valid) ? r_pend_pc : w_tgt;
    assign w_pc_inc = r_pc + 32'd4;

    // Launch = start a fresh request now; no older request is left outstanding.
    always_comb begin
        w_do_launch = 1'b0;
        case (r_state)
            S_IDLE:  w_do_launch = redirect_valid;
            S_REQ:   w_do_launch = redirect_valid && imem_ack;
            S_VALID: w_do_launch = redirect_valid;
            S_DROP:  w_do_launch = imem_ack;
            default: w_do_launch = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_iaddr   <= RESET_PC;
            r_pc      <= RESET_PC;
            r_idata   <= NOP_INSTR;
            r_pend_pc <= RESET_PC;
            r_req     <= 1'b0;
            r_valid   <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            r_err      <= 1'b0;
            r_pend_bad <= 1'b0;
`endif
        end else if (w_do_launch) begin
            r_valid <= 1'b0;
            r_idata <= NOP_INSTR;
`ifdef FETCH_ALIGN_CHECK_EN
            if (w_l_bad) begin
                r_state <= S_ERR;
                r_req   <= 1'b0;
                r_err   <= 1'b1;
            end else
`endif
            begin
                r_state <= S_REQ;
                r_req   <= 1'b1;
                r_iaddr <= w_l_pc;
                r_pc    <= w_l_pc;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                    r_req   <= 1'b1;
                end
                S_REQ: begin
                    if (redirect_valid) begin
                        // Old request still in flight: keep it on the bus, remember the target.
                        r_state   <= S_DROP;
                        r_pend_pc <= w_tgt;
                        r_pc      <= w_tgt;
`ifdef FETCH_ALIGN_CHECK_EN
                        r_pend_bad <= w_bad;
`endif
                    end else if (imem_ack) begin
                        r_state <= S_VALID;
                        r_idata <= imem_rdata;
                        r_valid <= 1'b1;
                        r_req   <= 1'b0;
                    end
                end
                S_VALID: begin
                    if (dec_ready) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                        r_iaddr <= w_pc_inc;
                        r_pc    <= w_pc_inc;
                        r_valid <= 1'b0;
                        r_idata <= NOP_INSTR;
                    end
                end
                S_DROP: begin
                    if (redirect_valid) begin
                        r_pend_pc <= w_tgt;
                        r_pc      <= w_tgt;
`ifdef FETCH_ALIGN_CHECK_EN
                        r_pend_bad <= w_bad;
`endif
                    end
                end
`ifdef FETCH_ALIGN_CHECK_EN
                S_ERR: begin
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                    r_idata <= NOP_INSTR;
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                    r_idata <= NOP_INSTR;
                end
            endcase
        end
    end

    assign iaddr       = r_iaddr;
    assign imem_req    = r_req;
    assign idata       = r_idata;
    assign pc          = r_pc;
    assign instr_valid = r_valid;

endmodule
